// File: rtl/ifetch_queue_pkg.sv
// rtl/ifetch_queue_pkg.sv - shared widths, entry type and PC helper for the fetch queue
package ifetch_queue_pkg;

  localparam int WORD_W = 32;
  localparam logic [WORD_W-1:0] PC_STEP = 32'd4;

  typedef struct packed {
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] inst;
  } fetch_entry_t;

  // Fetch addresses are always word aligned; low two bits are discarded.
  function automatic logic [WORD_W-1:0] align_pc(input logic [WORD_W-1:0] pc);
    return {pc[WORD_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifetch_queue_if.sv
// rtl/ifetch_queue_if.sv - memory, redirect and datapath handshakes of the fetch stage
interface ifetch_queue_if;
  import ifetch_queue_pkg::*;

  logic              imem_req_valid;
  logic              imem_req_ready;
  logic [WORD_W-1:0] imem_req_addr;
  logic              imem_resp_valid;
  logic [WORD_W-1:0] imem_resp_data;
  logic              redirect_valid;
  logic [WORD_W-1:0] redirect_pc;
  logic              inst_valid;
  logic              inst_ready;
  logic [WORD_W-1:0] inst;
  logic [WORD_W-1:0] inst_pc;

  // The fetch stage itself.
  modport master (
    output imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc,
    input  imem_req_ready, imem_resp_valid, imem_resp_data,
    input  redirect_valid, redirect_pc, inst_ready
  );

  // Memory and datapath side.
  modport slave (
    input  imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc,
    output imem_req_ready, imem_resp_valid, imem_resp_data,
    output redirect_valid, redirect_pc, inst_ready
  );

endinterface

// File: rtl/ifetch_queue_fetch_fifo.sv
// rtl/ifetch_queue_fetch_fifo.sv - DEPTH-entry FIFO of {pc, inst} with flush and async clear
module ifetch_queue_fetch_fifo
  import ifetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH)
) (
  input  logic         i_clk,
  input  logic         i_clear_n,
  input  logic         i_push,
  input  fetch_entry_t i_push_data,
  input  logic         i_pop,
  input  logic         i_flush,
  output fetch_entry_t o_head,
  output logic [PW:0]  o_count
);

  fetch_entry_t r_mem [DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [PW:0]   r_count;
  logic          w_do_push;
  logic          w_do_pop;

  // A flush discards any same-cycle write; a pop is still honoured.
  assign w_do_pop  = i_pop && (r_count != '0);
  assign w_do_push = i_push && !i_flush && (r_count != (PW+1)'(DEPTH));

  // Entry storage; contents are only meaningful while counted.
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_push_data;
  end

  // Pointers wrap naturally; count tracks occupancy.
  always_ff @(posedge i_clk or negedge i_clear_n) begin
    if (!i_clear_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + (PW+1)'(w_do_push) - (PW+1)'(w_do_pop);
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/ifetch_queue.sv
// rtl/ifetch_queue.sv - fetch PC, request credit, redirect handling and instruction queue
module ifetch_queue
  import ifetch_queue_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic clk,
  input  logic reset,
  ifetch_queue_if.master bus
);

  localparam int PW = $clog2(DEPTH);

  logic [WORD_W-1:0] r_fetch_pc;
  logic [WORD_W-1:0] r_req_pc;
  logic              r_pend_q;
  logic [PW:0]       w_count;
  logic [PW+1:0]     w_used;
  logic              w_credit;
  logic              w_req_fire;
  logic              w_push;
  logic              w_pop;
  logic              w_inst_valid;
  fetch_entry_t      w_head;
  fetch_entry_t      w_push_data;

  // Queued entries plus the one in flight must leave room for a new response.
  assign w_used   = {1'b0, w_count} + {{(PW+1){1'b0}}, r_pend_q};
  assign w_credit = w_used < (PW+2)'(DEPTH);

  assign bus.imem_req_valid = reset && !bus.redirect_valid && w_credit;
  assign bus.imem_req_addr  = r_fetch_pc;
  assign w_req_fire         = bus.imem_req_valid && bus.imem_req_ready;

  // Responses only count when we are waiting for one and not flushing.
  assign w_push       = r_pend_q && bus.imem_resp_valid && !bus.redirect_valid;
  assign w_push_data  = '{pc: r_req_pc, inst: bus.imem_resp_data};
  assign w_inst_valid = (w_count != '0);
  assign w_pop        = w_inst_valid && bus.inst_ready;

  ifetch_queue_fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_clk       (clk),
    .i_clear_n   (reset),
    .i_push      (w_push),
    .i_push_data (w_push_data),
    .i_pop       (w_pop),
    .i_flush     (bus.redirect_valid),
    .o_head      (w_head),
    .o_count     (w_count)
  );

  assign bus.inst_valid = w_inst_valid;
  assign bus.inst       = w_inst_valid ? w_head.inst : '0;
  assign bus.inst_pc    = w_inst_valid ? w_head.pc   : '0;

  // Fetch PC advances on acceptance; redirect restarts it and cancels the pending response.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fetch_pc <= RESET_PC;
      r_req_pc   <= RESET_PC;
      r_pend_q   <= 1'b0;
    end else if (bus.redirect_valid) begin
      r_fetch_pc <= align_pc(bus.redirect_pc);
      r_pend_q   <= 1'b0;
    end else begin
      r_pend_q <= w_req_fire;
      if (w_req_fire) begin
        r_req_pc   <= r_fetch_pc;
        r_fetch_pc <= r_fetch_pc + PC_STEP;
      end
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// tb/tb_ifetch_queue.sv - randomized bench for ifetch_queue against a queue-based reference model
module tb_ifetch_queue;
  import ifetch_queue_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  ifetch_queue_if bus();

  ifetch_queue #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // reference model state
  fetch_entry_t m_q[$];
  logic [31:0]  m_pc = RESET_PC;
  logic         m_pend = 1'b0;
  logic [31:0]  m_pend_pc = '0;

  // memory environment state
  logic        prev_fire = 1'b0;
  logic [31:0] prev_addr = '0;
  logic [31:0] salt = '0;

  // last sampled DUT outputs
  logic        obs_req_valid;
  logic [31:0] obs_req_addr;
  logic        obs_inst_valid;
  logic [31:0] obs_inst_pc;
  logic [31:0] obs_inst;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ salt;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_pc      = RESET_PC;
    m_pend    = 1'b0;
    m_pend_pc = '0;
    prev_fire = 1'b0;
  endtask

  // One clock: drive, sample at negedge+1 against the model, advance the model at posedge.
  task automatic step(input logic rdy, input logic ird, input logic rv,
                      input logic [31:0] rpc, input logic stray);
    logic        exp_req_v;
    logic        exp_inst_v;
    logic [31:0] exp_inst;
    logic [31:0] exp_inst_pc;
    logic        m_fire;
    logic        m_pop;
    logic        resp_v;
    logic [31:0] resp_d;
    logic        dut_fire;
    logic [31:0] dut_addr;
    bus.imem_req_ready = rdy;
    bus.inst_ready     = ird;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    if (prev_fire) begin
      bus.imem_resp_valid = 1'b1;
      bus.imem_resp_data  = mem_word(prev_addr);
    end else begin
      bus.imem_resp_valid = stray;
      bus.imem_resp_data  = $urandom;
    end
    resp_v = bus.imem_resp_valid;
    resp_d = bus.imem_resp_data;
    #1;
    exp_req_v   = rst_n && !rv && ((m_q.size() + int'(m_pend)) < DEPTH);
    exp_inst_v  = m_q.size() > 0;
    exp_inst    = exp_inst_v ? m_q[0].inst : 32'h0;
    exp_inst_pc = exp_inst_v ? m_q[0].pc : 32'h0;
    vectors += 5;
    if (bus.imem_req_valid !== exp_req_v) begin
      miscompares++;
      $display("FAIL req_valid got %0b exp %0b t=%0t", bus.imem_req_valid, exp_req_v, $time);
    end
    if (bus.imem_req_addr !== m_pc) begin
      miscompares++;
      $display("FAIL req_addr got %h exp %h t=%0t", bus.imem_req_addr, m_pc, $time);
    end
    if (bus.inst_valid !== exp_inst_v) begin
      miscompares++;
      $display("FAIL inst_valid got %0b exp %0b t=%0t", bus.inst_valid, exp_inst_v, $time);
    end
    if (bus.inst_pc !== exp_inst_pc) begin
      miscompares++;
      $display("FAIL inst_pc got %h exp %h t=%0t", bus.inst_pc, exp_inst_pc, $time);
    end
    if (bus.inst !== exp_inst) begin
      miscompares++;
      $display("FAIL inst got %h exp %h t=%0t", bus.inst, exp_inst, $time);
    end
    obs_req_valid  = bus.imem_req_valid;
    obs_req_addr   = bus.imem_req_addr;
    obs_inst_valid = bus.inst_valid;
    obs_inst_pc    = bus.inst_pc;
    obs_inst       = bus.inst;
    dut_fire = bus.imem_req_valid && rdy;
    dut_addr = bus.imem_req_addr;
    m_fire   = exp_req_v && rdy;
    m_pop    = exp_inst_v && ird;
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      if (m_pop) void'(m_q.pop_front());
      if (rv) begin
        m_q.delete();
        m_pend = 1'b0;
        m_pc   = {rpc[31:2], 2'b00};
      end else begin
        if (m_pend && resp_v) begin
          m_q.push_back('{pc: m_pend_pc, inst: resp_d});
          vectors++;
          if (m_q.size() > DEPTH) begin
            miscompares++;
            $display("FAIL overflow occupancy %0d exceeds %0d", m_q.size(), DEPTH);
          end
        end
        if (m_fire) begin
          m_pend_pc = m_pc;
          m_pc      = m_pc + 32'd4;
          m_pend    = 1'b1;
        end else begin
          m_pend = 1'b0;
        end
      end
    end
    prev_fire = rst_n && dut_fire;
    prev_addr = dut_addr;
    @(negedge clk);
  endtask

  task automatic test_reset();
    bus.imem_req_ready  = 1'b1;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = '0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_pc     = '0;
    bus.inst_ready      = 1'b1;
    @(negedge clk);
    #1;
    vectors += 4;
    if (bus.imem_req_valid !== 1'b0) begin miscompares++; $display("FAIL reset_req_valid got %0b exp 0", bus.imem_req_valid); end
    if (bus.inst_valid !== 1'b0) begin miscompares++; $display("FAIL reset_inst_valid got %0b exp 0", bus.inst_valid); end
    if (bus.inst !== 32'h0) begin miscompares++; $display("FAIL reset_inst got %h exp 0", bus.inst); end
    if (bus.inst_pc !== 32'h0) begin miscompares++; $display("FAIL reset_inst_pc got %h exp 0", bus.inst_pc); end
    model_reset();
    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    rst_n = 1'b1;
  endtask

  task automatic test_stream();
    for (int k = 1; k <= 12; k++) begin
      step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
      vectors++;
      if (obs_req_addr !== RESET_PC + 32'(4 * (k - 1))) begin
        miscompares++;
        $display("FAIL stream_addr cyc %0d got %h exp %h", k, obs_req_addr, RESET_PC + 32'(4 * (k - 1)));
      end
      if (k >= 3) begin
        vectors++;
        if (!obs_inst_valid || obs_inst_pc !== RESET_PC + 32'(4 * (k - 3))) begin
          miscompares++;
          $display("FAIL stream_pc cyc %0d got %0b/%h exp 1/%h", k, obs_inst_valid, obs_inst_pc, RESET_PC + 32'(4 * (k - 3)));
        end
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] first_pc;
    for (int k = 0; k < 10; k++) step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    vectors++;
    if (obs_req_valid !== 1'b0 || obs_inst_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL stall_full req_valid %0b inst_valid %0b exp 0/1", obs_req_valid, obs_inst_valid);
    end
    first_pc = '0;
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
      if (k == 0) first_pc = obs_inst_pc;
      vectors++;
      if (!obs_inst_valid || obs_inst_pc !== first_pc + 32'(4 * k)) begin
        miscompares++;
        $display("FAIL drain_order idx %0d got %0b/%h exp 1/%h", k, obs_inst_valid, obs_inst_pc, first_pc + 32'(4 * k));
      end
    end
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    vectors++;
    if (obs_inst_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL drain_empty inst_valid got %0b exp 0", obs_inst_valid);
    end
  endtask

  task automatic test_redirect();
    step(1'b1, 1'b0, 1'b1, 32'h0000_0200, 1'b0);
    for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 32'h0000_0103, 1'b0);
    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    vectors++;
    if (obs_req_valid !== 1'b1 || obs_req_addr !== 32'h0000_0100 || obs_inst_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL redirect_restart got %0b/%h/%0b exp 1/00000100/0", obs_req_valid, obs_req_addr, obs_inst_valid);
    end
    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    vectors++;
    if (obs_inst_valid !== 1'b1 || obs_inst_pc !== 32'h0000_0100) begin
      miscompares++;
      $display("FAIL redirect_first got %0b/%h exp 1/00000100", obs_inst_valid, obs_inst_pc);
    end
  endtask

  task automatic test_redirect_pop();
    step(1'b1, 1'b0, 1'b1, 32'h0000_0400, 1'b0);
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 32'h0000_0800, 1'b0);
    vectors++;
    if (obs_inst_valid !== 1'b1 || obs_inst_pc !== 32'h0000_0400) begin
      miscompares++;
      $display("FAIL redir_pop_head got %0b/%h exp 1/00000400", obs_inst_valid, obs_inst_pc);
    end
    for (int j = 1; j <= 4; j++) begin
      step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
      vectors++;
      if (j < 3) begin
        if (obs_inst_valid !== 1'b0) begin
          miscompares++;
          $display("FAIL redir_pop_stale cyc %0d got valid pc %h", j, obs_inst_pc);
        end
      end else if (obs_inst_valid !== 1'b1 || obs_inst_pc !== 32'h0000_0800 + 32'(4 * (j - 3))) begin
        miscompares++;
        $display("FAIL redir_pop_new cyc %0d got %0b/%h exp 1/%h", j, obs_inst_valid, obs_inst_pc, 32'h0000_0800 + 32'(4 * (j - 3)));
      end
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_addr [3];
    exp_addr[0] = 32'hFFFF_FFF8;
    exp_addr[1] = 32'hFFFF_FFFC;
    exp_addr[2] = 32'h0000_0000;
    step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
      vectors++;
      if (obs_req_addr !== exp_addr[k]) begin
        miscompares++;
        $display("FAIL wrap_addr idx %0d got %h exp %h", k, obs_req_addr, exp_addr[k]);
      end
    end
    for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic test_reset_midop();
    step(1'b1, 1'b0, 1'b1, 32'h0000_0300, 1'b0);
    for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    rst_n = 1'b0;
    #1;
    vectors += 4;
    if (bus.imem_req_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_req_valid got %0b exp 0", bus.imem_req_valid); end
    if (bus.inst_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_inst_valid got %0b exp 0", bus.inst_valid); end
    if (bus.inst !== 32'h0) begin miscompares++; $display("FAIL midrst_inst got %h exp 0", bus.inst); end
    if (bus.inst_pc !== 32'h0) begin miscompares++; $display("FAIL midrst_inst_pc got %h exp 0", bus.inst_pc); end
    model_reset();
    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    rst_n = 1'b1;
    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    vectors++;
    if (obs_req_valid !== 1'b1 || obs_req_addr !== RESET_PC) begin
      miscompares++;
      $display("FAIL midrst_restart got %0b/%h exp 1/%h", obs_req_valid, obs_req_addr, RESET_PC);
    end
    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    vectors++;
    if (obs_inst_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst_stray got valid pc %h exp no entry", obs_inst_pc);
    end
    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    vectors++;
    if (obs_inst_valid !== 1'b1 || obs_inst_pc !== RESET_PC || obs_inst !== mem_word(RESET_PC)) begin
      miscompares++;
      $display("FAIL midrst_first got %0b/%h/%h exp 1/%h/%h", obs_inst_valid, obs_inst_pc, obs_inst, RESET_PC, mem_word(RESET_PC));
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
           $urandom_range(0, 15) == 0, $urandom, 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    salt = $urandom;
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_redirect_pop();
    test_wrap();
    test_reset_midop();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
